// File: rtl/intercpu_sm_cluster.sv
// intercpu_sm_cluster: per-cluster 32-bit semaphore register shared by two CPU ports,
// round-robin arbitrated, with held-issue test-and-set and deadlock detection.
module intercpu_sm_cluster #(
  parameter logic [2:0] CLN_ID    = 3'h1,
  parameter int         DL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [2:0]  i_op0,
  input  logic [2:0]  i_op1,
  input  logic [4:0]  i_idx0,
  input  logic [4:0]  i_idx1,
  input  logic [2:0]  i_cln0,
  input  logic [2:0]  i_cln1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic [31:0] o_sm,
  output logic        o_deadlock
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} st_t;
  localparam logic [7:0] DL = 8'(DL_CYCLES);
  st_t         st_q [2];
  st_t         st_d [2];
  logic [31:0] sm_q, sm_d;
  logic        ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  req, elig, blk, srv, gnt, att;
  logic [2:0]  op  [2];
  logic [4:0]  idx [2];
  logic [2:0]  cln [2];
  logic [31:0] wd  [2];
  logic        sel, cond;
  logic [31:0] mask;
  assign req    = {i_req1, i_req0};
  assign op[0]  = i_op0;
  assign op[1]  = i_op1;
  assign idx[0] = i_idx0;
  assign idx[1] = i_idx1;
  assign cln[0] = i_cln0;
  assign cln[1] = i_cln1;
  assign wd[0]  = i_wdata0;
  assign wd[1]  = i_wdata1;
  always_comb begin
    elig = '0;
    blk  = '0;
    srv  = '0;
    att  = '0;
    for (int n = 0; n < 2; n++) begin
      att[n]  = cln[n] == CLN_ID;
      elig[n] = req[n] && att[n] && cln[n] != 3'd0 && st_q[n] != ACK;
      blk[n]  = elig[n] && op[n] == 3'd1 && sm_q[5'd31 - idx[n]];
      srv[n]  = elig[n] && !blk[n];
    end
    gnt[0] = srv[0] && (!srv[1] || !ptr_q);
    gnt[1] = srv[1] && (!srv[0] || ptr_q);
    sel    = gnt[1];
    mask   = 32'h8000_0000 >> idx[sel];
    sm_d   = !(|gnt) ? sm_q :
             (op[sel] == 3'd1 || op[sel] == 3'd3) ? (sm_q | mask) :
             op[sel] == 3'd2 ? (sm_q & ~mask) :
             op[sel] == 3'd4 ? wd[sel] : sm_q;
    ptr_d  = |gnt ? ~ptr_q : ptr_q;
    for (int n = 0; n < 2; n++)
      st_d[n] = gnt[n] ? ACK :
                blk[n] ? WAIT :
                (st_q[n] == WAIT && req[n] && att[n]) ? WAIT : IDLE;
    // deadlock: every attached port parked in WAIT, at least one attached
    cond  = |att && (!att[0] || st_q[0] == WAIT) && (!att[1] || st_q[1] == WAIT);
    cnt_d = !cond ? 8'd0 : cnt_q == DL ? cnt_q : cnt_q + 8'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_q  <= '0;
      ptr_q <= 1'b0;
      cnt_q <= '0;
      for (int n = 0; n < 2; n++) st_q[n] <= IDLE;
    end else begin
      sm_q  <= sm_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int n = 0; n < 2; n++) st_q[n] <= st_d[n];
    end
  end
  assign o_sm       = sm_q;
  assign o_ack0     = st_q[0] == ACK;
  assign o_ack1     = st_q[1] == ACK;
  assign o_deadlock = cond && cnt_q == DL;
endmodule
